// File: rtl/traffic_timer_sensor_if.sv
// traffic_timer_sensor_if: signals between the light FSM/sensor side and the timer/sensor front-end
interface traffic_timer_sensor_if #(
    parameter int CNT_W = 8
);
    logic             ST;
    logic             car_raw;
    logic             TS;
    logic             TL;
    logic             C;
    logic [CNT_W-1:0] cnt;

    modport master (
        output ST,
        output car_raw,
        input  TS,
        input  TL,
        input  C,
        input  cnt
    );

    modport slave (
        input  ST,
        input  car_raw,
        output TS,
        output TL,
        output C,
        output cnt
    );
endinterface

// File: rtl/traffic_timer_sensor.sv
// traffic_timer_sensor: interval timer (TS/TL) and car sensor conditioning (C); CAR_DEBOUNCE_EN adds the debounce FSM
module traffic_timer_sensor #(
    parameter int SHORT_CNT = 4,
    parameter int LONG_CNT  = 16,
    parameter int CNT_W     = 8,
    parameter int DEB_CNT   = 3
) (
    input logic                  clk,
    input logic                  reset,
    traffic_timer_sensor_if.slave bus
);
    localparam logic [CNT_W-1:0] SHORT_V = CNT_W'(SHORT_CNT);
    localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(LONG_CNT);

    if (SHORT_CNT < 1 || SHORT_CNT >= LONG_CNT || LONG_CNT > (2 ** CNT_W) - 1 || DEB_CNT < 1) begin : g_bad_params
        $error("traffic_timer_sensor: illegal parameter combination");
    end

    logic [CNT_W-1:0] cnt_q;
    logic             sync1;
    logic             sync2;

    // interval counter: ST restarts from zero, otherwise count up and saturate at LONG_CNT
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (bus.ST)
            cnt_q <= '0;
        else if (cnt_q != LONG_V)
            cnt_q <= cnt_q + 1'b1;
    end

    // decoded from the register only so the light FSM's combinational ST never loops back
    assign bus.cnt = cnt_q;
    assign bus.TS  = cnt_q >= SHORT_V;
    assign bus.TL  = cnt_q >= LONG_V;

    // two-flop synchronizer for the asynchronous car sensor
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.car_raw;
            sync2 <= sync1;
        end
    end

`ifdef CAR_DEBOUNCE_EN
    localparam int             DW    = (DEB_CNT < 2) ? 1 : $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0]  DEB_V = DW'(DEB_CNT);
    localparam logic [DW-1:0]  ONE_V = DW'(1);

    typedef enum logic [1:0] {
        LO,
        CHK_HI,
        HI,
        CHK_LO
    } deb_state_t;

    deb_state_t    state_q;
    deb_state_t    state_d;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;

    // debounce state and stability counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LO;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // debounce next state: a level change must hold through DEB_CNT counting cycles to take effect
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            LO: begin
                if (sync2) begin
                    state_d = CHK_HI;
                    dcnt_d  = ONE_V;
                end
            end
            CHK_HI: begin
                if (!sync2)
                    state_d = LO;
                else if (dcnt_q == DEB_V)
                    state_d = HI;
                else
                    dcnt_d = dcnt_q + 1'b1;
            end
            HI: begin
                if (!sync2) begin
                    state_d = CHK_LO;
                    dcnt_d  = ONE_V;
                end
            end
            CHK_LO: begin
                if (sync2)
                    state_d = HI;
                else if (dcnt_q == DEB_V)
                    state_d = LO;
                else
                    dcnt_d = dcnt_q + 1'b1;
            end
            default: state_d = LO;
        endcase
    end

    // Moore output straight from the state register
    assign bus.C = (state_q == HI) || (state_q == CHK_LO);
`else
    assign bus.C = sync2;
`endif
endmodule

// File: tb/tb_traffic_timer_sensor.sv
// tb_traffic_timer_sensor: directed stimulus, cycle-by-cycle reference model plus literal spot checks
module tb_traffic_timer_sensor;
    localparam int SHORT = 4;
    localparam int LONG  = 16;
    localparam int DEB   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    traffic_timer_sensor_if #(.CNT_W(8)) bus ();

    traffic_timer_sensor #(
        .SHORT_CNT(SHORT),
        .LONG_CNT (LONG),
        .CNT_W    (8),
        .DEB_CNT  (DEB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // reference model: time since last restart, sampled-sensor history, run length of disagreement
    int since = 0;
    int run = 0;
    bit m_valid = 1'b0;
    bit s1 = 1'b0;
    bit s2 = 1'b0;
    bit mc = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            since = 0;
            run = 0;
            s1 = 1'b0;
            s2 = 1'b0;
            mc = 1'b0;
            m_valid = 1'b1;
        end else begin
            since = bus.ST ? 0 : since + 1;
`ifdef CAR_DEBOUNCE_EN
            run = (s2 != mc) ? run + 1 : 0;
            if (run == DEB + 1) begin
                mc = s2;
                run = 0;
            end
`endif
            s2 = s1;
            s1 = bus.car_raw;
        end
    end

    // compare every cycle once the model has seen a reset edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_cnt", bus.cnt, (since > LONG) ? LONG : since);
            check("model_TS", bus.TS, since >= SHORT);
            check("model_TL", bus.TL, since >= LONG);
`ifdef CAR_DEBOUNCE_EN
            check("model_C", bus.C, mc);
`else
            check("model_C", bus.C, s2);
`endif
        end
    end

    initial begin
        bus.ST = 1'b0;
        bus.car_raw = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_cnt", bus.cnt, 0);
        check("reset_TS", bus.TS, 0);
        check("reset_TL", bus.TL, 0);
        check("reset_C", bus.C, 0);
        repeat (3) @(negedge clk);
        check("idle_cnt3_TS", bus.TS, 0);
        @(negedge clk);
        check("idle_cnt4", bus.cnt, 4);
        check("idle_TS_rise", bus.TS, 1);
        check("idle_TL_low", bus.TL, 0);
        repeat (11) @(negedge clk);
        check("idle_TL_15", bus.TL, 0);
        @(negedge clk);
        check("idle_cnt16", bus.cnt, 16);
        check("idle_TL_rise", bus.TL, 1);
        repeat (10) @(negedge clk);
        check("idle_sat", bus.cnt, 16);

        bus.ST = 1'b1;
        @(negedge clk);
        bus.ST = 1'b0;
        repeat (7) @(negedge clk);
        check("restart_pre7", bus.cnt, 7);
        bus.ST = 1'b1;
        @(negedge clk);
        bus.ST = 1'b0;
        check("restart_cnt0", bus.cnt, 0);
        check("restart_TS0", bus.TS, 0);
        check("restart_TL0", bus.TL, 0);
        repeat (3) @(negedge clk);
        check("restart_TS_edge3", bus.TS, 0);
        @(negedge clk);
        check("restart_TS_edge4", bus.TS, 1);

        bus.ST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("held_cnt", bus.cnt, 0);
            check("held_TS", bus.TS, 0);
            check("held_TL", bus.TL, 0);
        end
        bus.ST = 1'b0;
        @(negedge clk);
        check("held_resume", bus.cnt, 1);

        bus.car_raw = 1'b1;
        repeat (11) @(negedge clk);
        check("rst_st_pre_cnt", bus.cnt, 12);
        check("rst_st_pre_C", bus.C, 1);
        reset = 1'b1;
        bus.ST = 1'b1;
        @(negedge clk);
        check("rst_st_cnt", bus.cnt, 0);
        check("rst_st_TS", bus.TS, 0);
        check("rst_st_C", bus.C, 0);
        reset = 1'b0;
        bus.ST = 1'b0;
        bus.car_raw = 1'b0;
        repeat (8) @(negedge clk);

`ifdef CAR_DEBOUNCE_EN
        bus.car_raw = 1'b1;
        repeat (2) @(negedge clk);
        bus.car_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("deb_glitch_C", bus.C, 0);
        end
        bus.car_raw = 1'b1;
        repeat (5) @(negedge clk);
        check("deb_rise_edge5", bus.C, 0);
        @(negedge clk);
        check("deb_rise_edge6", bus.C, 1);
        repeat (3) @(negedge clk);
        bus.car_raw = 1'b0;
        @(negedge clk);
        bus.car_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("deb_dip_C", bus.C, 1);
        end
        bus.car_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("deb_fall_C", bus.C, 0);
`else
        bus.car_raw = 1'b1;
        @(negedge clk);
        check("raw_rise_edge1", bus.C, 0);
        @(negedge clk);
        check("raw_rise_edge2", bus.C, 1);
        bus.car_raw = 1'b0;
        repeat (3) @(negedge clk);
        bus.car_raw = 1'b1;
        @(negedge clk);
        bus.car_raw = 1'b0;
        check("raw_pulse_pre", bus.C, 0);
        @(negedge clk);
        check("raw_pulse_on", bus.C, 1);
        @(negedge clk);
        check("raw_pulse_off", bus.C, 0);
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
